// File: rtl/expansion_pkg.sv
// Shared constants and helpers for the serial expansion plugins.
// State codes are plain constants so legacy tools can consume them unchanged.
package expansion_pkg;

  localparam int unsigned StateW = 3;

  localparam logic [StateW-1:0] StIdle  = 3'd0;
  localparam logic [StateW-1:0] StLoad  = 3'd1;
  localparam logic [StateW-1:0] StHold  = 3'd2;
  localparam logic [StateW-1:0] StLow   = 3'd3;
  localparam logic [StateW-1:0] StHigh  = 3'd4;
  localparam logic [StateW-1:0] StLatch = 3'd5;
  localparam logic [StateW-1:0] StFin   = 3'd6;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/expansion_phase_tick.sv
// Free-running phase divider: one tick every DIVIDER clk cycles.
// The counter starts at DIVIDER-1 out of reset, so the first tick lands DIVIDER cycles later.
module expansion_phase_tick
  import expansion_pkg::*;
#(
  parameter int unsigned DIVIDER = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = clog2_min1(DIVIDER);
  localparam logic [CntW-1:0] Reload = CntW'(DIVIDER - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == '0);
    cnt_d = tick ? Reload : cnt_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/expansion_shiftreg_chain.sv
// Serial expander for daisy-chained 74HC595 outputs and 74HC165 inputs.
// One frame shifts data_out out and data_in in over a shared clock and load/latch line.
module expansion_shiftreg_chain
  import expansion_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DIVIDER         = 100000,
  parameter bit          MSB_FIRST       = 1'b1,
  parameter bit          LOAD_ACTIVE_LOW = 1'b1,
  parameter bit          CONTINUOUS      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_in,
  output logic             SHIFT_OUT,
  input  logic             SHIFT_IN,
  output logic             SHIFT_CLK,
  output logic             SHIFT_LOAD,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned IdxW = clog2_min1(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);
  localparam logic LoadOn = LOAD_ACTIVE_LOW ? 1'b0 : 1'b1;

  logic              tick;
  logic [StateW-1:0] state_q, state_d;
  logic              pending_q, pending_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic [WIDTH-1:0]  rx_q, rx_d;
  logic [WIDTH-1:0]  data_in_q, data_in_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              shift_clk_q, shift_clk_d;
  logic              shift_out_q, shift_out_d;
  logic              shift_load_q, shift_load_d;
  logic [IdxW-1:0]   bit_pos_q, bit_pos_d;

  expansion_phase_tick #(
    .DIVIDER(DIVIDER)
  ) u_phase_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_comb begin
    bit_pos_q = MSB_FIRST ? (LastIdx - idx_q) : idx_q;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    data_in_d    = data_in_q;
    frame_done_d = 1'b0;
    // Requests arriving while idle or mid-frame collapse into a single pending frame.
    pending_d    = pending_q | (start & !CONTINUOUS);

    if (tick) begin
      case (state_q)
        StIdle: begin
          if (CONTINUOUS || pending_q) begin
            state_d   = StLoad;
            pending_d = 1'b0;
          end
        end
        StLoad:  state_d = StHold;
        StHold:  state_d = StLow;
        StLow: begin
          rx_d[bit_pos_q] = SHIFT_IN;
          state_d         = StHigh;
        end
        StHigh: begin
          if (idx_q == LastIdx) begin
            state_d = StLatch;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StLow;
          end
        end
        StLatch: begin
          state_d      = StFin;
          data_in_d    = rx_q;
          frame_done_d = 1'b1;
        end
        StFin: begin
          if (CONTINUOUS || pending_q) begin
            state_d   = StLoad;
            pending_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Shadow the outgoing word on LOAD entry so later data_out changes wait a frame.
    if ((state_d == StLoad) && (state_q != StLoad)) begin
      tx_d  = data_out;
      idx_d = '0;
    end
  end

  // Pin levels are registered from the next state so they change cleanly with it.
  always_comb begin
    bit_pos_d    = MSB_FIRST ? (LastIdx - idx_d) : idx_d;
    busy_d       = (state_d != StIdle);
    shift_clk_d  = (state_d == StHigh);
    shift_out_d  = ((state_d == StLow) || (state_d == StHigh)) ? tx_d[bit_pos_d] : 1'b0;
    shift_load_d = ((state_d == StLoad) || (state_d == StLatch)) ? LoadOn : ~LoadOn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pending_q    <= 1'b0;
      idx_q        <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      data_in_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      shift_clk_q  <= 1'b0;
      shift_out_q  <= 1'b0;
      shift_load_q <= ~LoadOn;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      data_in_q    <= data_in_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      shift_clk_q  <= shift_clk_d;
      shift_out_q  <= shift_out_d;
      shift_load_q <= shift_load_d;
    end
  end

  assign data_in    = data_in_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign SHIFT_CLK  = shift_clk_q;
  assign SHIFT_OUT  = shift_out_q;
  assign SHIFT_LOAD = shift_load_q;

endmodule

// File: tb/tb_expansion_shiftreg_chain.sv
// Bench for expansion_shiftreg_chain: four configurations, with 595/165 chain models on the pins.
// Continuous instances are checked every cycle against frame timing derived from elapsed cycles.
module tb_expansion_shiftreg_chain;

  logic clk;
  logic rst_n, rst_n_c;
  logic start_ab, start_c;

  // Instance index: 0 = W16 MSB-first, 1 = W16 LSB-first, 2 = W8 one-shot, 3 = W1 load-active-high
  logic [3:0] sclk, sload, sout, sin, busy, done;
  logic [15:0] dout_a, dout_b, din_a, din_b;
  logic [7:0]  dout_c, din_c;
  logic        dout_d, din_d;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc;

  logic [15:0] sr595 [4];
  logic [15:0] latch595 [4];
  logic [15:0] cap [4];
  int cnt165 [4];
  int rise_cnt [4];
  int done_cnt [4];
  int busy_fall [4];
  int load_rise [4];
  int last_done [4];
  int last_lr [4];
  logic [3:0] prev_clk, prev_load, prev_busy;
  bit seen_a, seen_b;

  expansion_shiftreg_chain #(.WIDTH(16), .DIVIDER(2), .MSB_FIRST(1'b1), .LOAD_ACTIVE_LOW(1'b1),
                             .CONTINUOUS(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_ab), .data_out(dout_a), .data_in(din_a),
    .SHIFT_OUT(sout[0]), .SHIFT_IN(sin[0]), .SHIFT_CLK(sclk[0]), .SHIFT_LOAD(sload[0]),
    .busy(busy[0]), .frame_done(done[0]));

  expansion_shiftreg_chain #(.WIDTH(16), .DIVIDER(2), .MSB_FIRST(1'b0), .LOAD_ACTIVE_LOW(1'b1),
                             .CONTINUOUS(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_ab), .data_out(dout_b), .data_in(din_b),
    .SHIFT_OUT(sout[1]), .SHIFT_IN(sin[1]), .SHIFT_CLK(sclk[1]), .SHIFT_LOAD(sload[1]),
    .busy(busy[1]), .frame_done(done[1]));

  expansion_shiftreg_chain #(.WIDTH(8), .DIVIDER(1), .MSB_FIRST(1'b1), .LOAD_ACTIVE_LOW(1'b1),
                             .CONTINUOUS(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n_c), .start(start_c), .data_out(dout_c), .data_in(din_c),
    .SHIFT_OUT(sout[2]), .SHIFT_IN(sin[2]), .SHIFT_CLK(sclk[2]), .SHIFT_LOAD(sload[2]),
    .busy(busy[2]), .frame_done(done[2]));

  expansion_shiftreg_chain #(.WIDTH(1), .DIVIDER(2), .MSB_FIRST(1'b1), .LOAD_ACTIVE_LOW(1'b0),
                             .CONTINUOUS(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_ab), .data_out(dout_d), .data_in(din_d),
    .SHIFT_OUT(sout[3]), .SHIFT_IN(sin[3]), .SHIFT_CLK(sclk[3]), .SHIFT_LOAD(sload[3]),
    .busy(busy[3]), .frame_done(done[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges since the shared reset released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  function automatic int wk(input int k);
    case (k)
      0, 1:    return 16;
      2:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int dk(input int k);
    return (k == 2) ? 1 : 2;
  endfunction

  function automatic bit msbk(input int k);
    return (k != 1);
  endfunction

  function automatic bit lalk(input int k);
    return (k != 3);
  endfunction

  function automatic logic [15:0] doutk(input int k);
    case (k)
      0:       return dout_a;
      1:       return dout_b;
      2:       return {8'h00, dout_c};
      default: return {15'h0, dout_d};
    endcase
  endfunction

  function automatic logic [15:0] dink(input int k);
    case (k)
      0:       return din_a;
      1:       return din_b;
      2:       return {8'h00, din_c};
      default: return {15'h0, din_d};
    endcase
  endfunction

  // Word each 165 chain presents on its parallel inputs.
  function automatic logic [15:0] rxk(input int k);
    case (k)
      0, 1:    return 16'h1234;
      2:       return 16'h0096;
      default: return 16'h0001;
    endcase
  endfunction

  function automatic logic [15:0] maskk(input int k);
    return 16'hFFFF >> (16 - wk(k));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected pins of a free-running instance, from elapsed cycles and the frame layout
  // LOAD, HOLD, (LOW, HIGH) x W, LATCH, FIN -- each phase D cycles.
  task automatic chk_cont(input int k, input int n);
    int w, d, nph, s, p, i, fin_at;
    logic act_exp;
    w = wk(k);
    d = dk(k);
    nph = 2 * w + 4;
    fin_at = (2 * w + 3) * d;
    if (n < d) begin
      chk($sformatf("idle_clk%0d", k), 32'(sclk[k]), 0);
      chk($sformatf("idle_load%0d", k), 32'(sload[k]), 32'(lalk(k)));
      chk($sformatf("idle_busy%0d", k), 32'(busy[k]), 0);
      chk($sformatf("idle_din%0d", k), 32'(dink(k)), 0);
    end else begin
      s = n - d;
      p = (s / d) % nph;
      act_exp = (p == 0) || (p == 2 * w + 2);
      chk($sformatf("clk%0d", k), 32'(sclk[k]),
          32'((p >= 3) && (p <= 2 * w + 1) && (p % 2 == 1)));
      chk($sformatf("load%0d", k), 32'(sload[k]), 32'(lalk(k) ? !act_exp : act_exp));
      chk($sformatf("busy%0d", k), 32'(busy[k]), 1);
      chk($sformatf("done%0d", k), 32'(done[k]), 32'((s % (nph * d)) == fin_at));
      chk($sformatf("din%0d", k), 32'(dink(k)), (s >= fin_at) ? 32'(rxk(k)) : 0);
      if ((p >= 2) && (p <= 2 * w + 1)) begin
        i = (p - 2) / 2;
        chk($sformatf("sout%0d_bit%0d", k, i), 32'(sout[k]),
            32'(msbk(k) ? doutk(k)[w-1-i] : doutk(k)[i]));
      end
    end
  endtask

  // Chain models and the per-cycle compare, all on the falling edge.
  initial begin
    logic rise, act;
    logic [15:0] word;
    int w;
    sin = '0;
    prev_clk = '0;
    prev_load = '0;
    prev_busy = '0;
    seen_a = 1'b0;
    seen_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sr595[k] = '0; latch595[k] = '0; cap[k] = '0; cnt165[k] = 0; rise_cnt[k] = 0;
      done_cnt[k] = 0; busy_fall[k] = 0; load_rise[k] = 0; last_done[k] = -1; last_lr[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        w = wk(k);
        rise = sclk[k] & ~prev_clk[k];
        act = (sload[k] == !lalk(k));
        if (rise) begin
          rise_cnt[k]++;
          cap[k] = {cap[k][14:0], sout[k]};
          if (msbk(k)) sr595[k] = ((sr595[k] << 1) | {15'h0, sout[k]}) & maskk(k);
          else         sr595[k] = (sr595[k] >> 1) | ({15'h0, sout[k]} << (w - 1));
        end
        if (sload[k] && !prev_load[k]) begin
          latch595[k] = sr595[k];
          load_rise[k]++;
        end
        if (act)       cnt165[k] = 0;
        else if (rise) cnt165[k]++;
        word = rxk(k);
        if (cnt165[k] < w) sin[k] = msbk(k) ? word[w-1-cnt165[k]] : word[cnt165[k]];
        else               sin[k] = 1'b0;
        if (done[k]) done_cnt[k]++;
        if (prev_busy[k] && !busy[k]) busy_fall[k]++;
      end
      prev_clk = sclk;
      prev_load = sload;
      prev_busy = busy;

      if (rst_n) begin
        chk_cont(0, ncyc);
        chk_cont(1, ncyc);
        chk_cont(3, ncyc);
        if (!seen_a && rise_cnt[0] == 16) begin
          chk("a_serial_msb_first", 32'(cap[0]), 32'h0000_A55A);
          seen_a = 1'b1;
        end
        if (!seen_b && rise_cnt[1] == 16) begin
          chk("b_serial_lsb_first", 32'(cap[1]), 32'h0000_5AA5);
          seen_b = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
          if (k != 2 && done[k]) begin
            chk($sformatf("latch595_%0d", k), 32'(latch595[k]), 32'(doutk(k)));
            if (last_done[k] >= 0)
              chk($sformatf("period%0d", k), 32'(ncyc - last_done[k]), (k == 3) ? 12 : 72);
            last_done[k] = ncyc;
          end
        end
        if (done[3]) begin
          chk("d_load_pulses", 32'(load_rise[3] - last_lr[3]), 2);
          last_lr[3] = load_rise[3];
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_start;
    start_c = 1'b1;
    step(1);
    start_c = 1'b0;
  endtask

  function automatic bit cond_met(input int what, input int target);
    case (what)
      0:       return rise_cnt[2] >= target;
      1:       return done_cnt[2] >= target;
      2:       return busy[2] == 1'b0;
      default: return busy[2] == 1'b1;
    endcase
  endfunction

  // what: 0 rises reach target, 1 frame_done count reaches target, 2 idle, 3 busy.
  task automatic wait_for(input int what, input int target, input int budget, input string name);
    int i;
    i = 0;
    while (!cond_met(what, target) && i < budget) begin
      step(1);
      i++;
    end
    if (!cond_met(what, target)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out after %0d cycles, condition still false", name, budget);
    end
  endtask

  initial begin
    int base_r, base_d, base_f;
    rst_n = 1'b1;
    rst_n_c = 1'b1;
    start_ab = 1'b0;
    start_c = 1'b0;
    dout_a = 16'hA55A;
    dout_b = 16'hA55A;
    dout_c = 8'hC3;
    dout_d = 1'b1;
    #1;
    rst_n = 1'b0;
    rst_n_c = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_clk%0d", k), 32'(sclk[k]), 0);
      chk($sformatf("rst_out%0d", k), 32'(sout[k]), 0);
      chk($sformatf("rst_load%0d", k), 32'(sload[k]), 32'(lalk(k)));
      chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 0);
      chk($sformatf("rst_done%0d", k), 32'(done[k]), 0);
      chk($sformatf("rst_din%0d", k), 32'(dink(k)), 0);
    end
    #19;
    rst_n = 1'b1;
    rst_n_c = 1'b1;

    // One-shot instance: quiet until asked.
    base_r = rise_cnt[2];
    step(20);
    chk("c_no_edges_idle", 32'(rise_cnt[2] - base_r), 0);
    chk("c_idle_busy", 32'(busy[2]), 0);
    chk("c_idle_load", 32'(sload[2]), 1);

    // Single request -> single frame.
    base_r = rise_cnt[2];
    base_d = done_cnt[2];
    pulse_start();
    wait_for(1, base_d + 1, 60, "c_frame1_done");
    wait_for(2, 0, 60, "c_frame1_idle");
    step(3);
    chk("c_frame1_rises", 32'(rise_cnt[2] - base_r), 8);
    chk("c_frame1_dones", 32'(done_cnt[2] - base_d), 1);
    chk("c_frame1_busy", 32'(busy[2]), 0);
    chk("c_frame1_din", 32'(din_c), 32'h96);
    chk("c_frame1_latch", 32'(latch595[2]), 32'hC3);

    // Three requests during one frame -> exactly one extra, back-to-back.
    base_r = rise_cnt[2];
    base_d = done_cnt[2];
    base_f = busy_fall[2];
    pulse_start();
    step(3);
    pulse_start();
    step(3);
    pulse_start();
    wait_for(1, base_d + 2, 100, "c_multi_done");
    wait_for(2, 0, 100, "c_multi_idle");
    step(5);
    chk("c_multi_rises", 32'(rise_cnt[2] - base_r), 16);
    chk("c_multi_dones", 32'(done_cnt[2] - base_d), 2);
    chk("c_multi_back_to_back", 32'(busy_fall[2] - base_f), 1);

    // data_out change mid-frame lands in the following frame only.
    dout_c = 8'hFF;
    base_d = done_cnt[2];
    pulse_start();
    step(6);
    dout_c = 8'h00;
    pulse_start();
    wait_for(1, base_d + 1, 60, "c_shadow_done1");
    chk("c_shadow_first", 32'(latch595[2]), 32'hFF);
    wait_for(1, base_d + 2, 60, "c_shadow_done2");
    chk("c_shadow_second", 32'(latch595[2]), 32'h00);
    wait_for(2, 0, 60, "c_shadow_idle");

    // Reset during HIGH of bit 5.
    dout_c = 8'h5A;
    base_r = rise_cnt[2];
    pulse_start();
    wait_for(0, base_r + 6, 60, "c_reach_bit5");
    chk("c_pre_reset_clk", 32'(sclk[2]), 1);
    rst_n_c = 1'b0;
    #1;
    chk("c_reset_clk", 32'(sclk[2]), 0);
    chk("c_reset_load", 32'(sload[2]), 1);
    chk("c_reset_din", 32'(din_c), 0);
    chk("c_reset_busy", 32'(busy[2]), 0);
    step(2);
    rst_n_c = 1'b1;
    step(4);
    chk("c_post_reset_idle", 32'(busy[2]), 0);
    base_r = rise_cnt[2];
    base_d = done_cnt[2];
    pulse_start();
    wait_for(3, 0, 20, "c_restart_busy");
    chk("c_restart_in_load", 32'(sload[2]), 0);
    chk("c_restart_no_edges", 32'(rise_cnt[2] - base_r), 0);
    wait_for(1, base_d + 1, 60, "c_restart_done");
    chk("c_restart_rises", 32'(rise_cnt[2] - base_r), 8);
    chk("c_restart_din", 32'(din_c), 32'h96);
    chk("c_restart_latch", 32'(latch595[2]), 32'h5A);

    // Let the free-running instances cover several more frames.
    step(300);
    chk("a_serial_seen", 32'(seen_a), 1);
    chk("b_serial_seen", 32'(seen_b), 1);
    chk("a_frames_seen", 32'(done_cnt[0] >= 3), 1);
    chk("d_frames_seen", 32'(done_cnt[3] >= 10), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
